operand_fetch: RTL and testbench
================================

# operand_fetch

Per-FU operand-read stage between the reservation station and the execution units. Accepts one issued uop per FU lane, reads its source operands from the physical register file (with same-cycle writeback bypass), and holds uop plus operands in a per-lane output register handed to the FU under valid/ready. Applies flush and single-uop recovery kills to in-flight entries.

## Interface
- DATA_W, 32: operand width.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- rs_valid  in  FU_NUM  per-lane issue valid from the RS.
- rs_ready  out  FU_NUM  per-lane accept; the RS consumes its entry on valid&ready.
- rs_uop  in  FU_NUM x rs_uop_t  issued uop per lane.
- prf_raddr  out  2*FU_NUM x PHYS_W  read addresses; lane f uses port 2f for src1 and 2f+1 for src2.
- prf_rdata  in  2*FU_NUM x DATA_W  combinational read data, pre-write value on a same-cycle write.
- wb_valid  in  1  CDB writeback valid.
- wb_pd  in  PHYS_W  CDB destination tag.
- wb_data  in  DATA_W  CDB result.
- ex_valid  out  FU_NUM  output register valid per lane.
- ex_ready  in  FU_NUM  FU accept.
- ex_uop  out  FU_NUM x rs_uop_t  registered uop.
- ex_src1, ex_src2  out  FU_NUM x DATA_W  registered operands.
- flush_valid  in  1  kill everything.
- recover_valid  in  1  kill one uop.
- recover_rob_idx  in  ROB_W  kill target ROB index.
- recover_epoch  in  EPOCH_W  kill target epoch.
- issued_cnt  out  32  count of uops accepted from the RS, wraps modulo 2^32.

## Operation
- Lanes are fully independent. Each lane has a one-entry pipeline register (valid, uop, src1, src2).
- Read addresses: prf_raddr[2f] = rs_uop[f].prs1, prf_raddr[2f+1] = rs_uop[f].prs2, driven combinationally whether or not rs_valid is asserted.
- Operand select per source: uses_rsN=0 gives 0. Otherwise wb_valid with wb_pd==prsN gives wb_data (bypass). Otherwise prf_rdata.
- rs_ready[f] = !flush_valid && !recover_valid && (!ex_valid[f] || ex_ready[f]). Recovery cycles are never capture cycles, which matches the RS, since it does not consume an issue entry during flush or recover.
- Capture: when rs_valid[f]&&rs_ready[f], the lane register loads uop and selected operands and sets valid. When ex_valid&&ex_ready without a capture, valid clears. When both occur in one cycle, the register is replaced (pass-through at full throughput).
- Stalled entry (ex_valid=1, ex_ready=0): uop and operands hold unchanged. There is no re-bypass, because operands were complete at capture.
- Priority per cycle: reset > flush > recover > normal update.
- Flush: all ex_valid clear next cycle. Data registers are don't-care.
- Recover: every lane with ex_valid && ex_uop.rob_idx==recover_rob_idx && ex_uop.epoch==recover_epoch clears valid. Other lanes hold, even if ex_ready is asserted.
- issued_cnt increments by popcount(rs_valid & rs_ready) each cycle and is unaffected by flush or recover.

## Timing
- Reset: ex_valid=0, ex_uop=0, ex_src1=ex_src2=0, issued_cnt=0. rs_ready is combinational: all 1 during reset deassertion, unless flush or recover is high.
- Latency: uop handshaked at cycle N appears on ex_* at cycle N+1.
- Throughput: 1 uop/lane/cycle with ex_ready held high.
- ex_valid never drops without ex_ready, flush, or a recover match.
- ex_uop and ex_src* are stable while ex_valid && !ex_ready.
- No combinational path from rs_valid to rs_ready. ex_ready to rs_ready is combinational.
- Mid-operation reset clears all lanes immediately (asynchronously).

## Test plan
- Basic: lane 0 issues prs1=5 (PRF=0x11) and prs2=7 (PRF=0x22) at cycle 3 -> cycle 4 shows ex_valid[0]=1, src1=0x11, src2=0x22, and issued_cnt=1.
- Bypass: issue prs1=9 with wb_valid, wb_pd=9, wb_data=0xABCD, PRF=0xDEAD in the same cycle -> ex_src1=0xABCD. With uses_rs2=0 -> ex_src2=0.
- Backpressure: ex_ready[1]=0 for 3 cycles with an entry held -> rs_ready[1]=0 and ex_* is unchanged. Next cycle ex_ready=1 with a new issue -> new uop replaces the old one with no bubble.
- Recover: lanes 0 and 2 hold rob_idx 4 and 6 in epoch 1, then recover(rob 6, epoch 1) -> only ex_valid[2] clears. Same cycle, rs_ready is all 0 and no capture occurs.
- Flush with rs_valid high on all lanes -> all ex_valid=0 next cycle and issued_cnt is unchanged.
- Async reset asserted mid-stall -> all outputs at their reset values before the next clk edge.

Source files
------------

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - per-lane operand read stage with writeback bypass and kill handling
package operand_fetch_pkg;
    localparam int FU_NUM  = 3;
    localparam int PHYS_W  = 7;
    localparam int ROB_W   = 6;
    localparam int EPOCH_W = 2;

    typedef struct packed {
        logic [7:0]         opcode;
        logic [PHYS_W-1:0]  pd;
        logic [PHYS_W-1:0]  prs1;
        logic [PHYS_W-1:0]  prs2;
        logic               uses_rs1;
        logic               uses_rs2;
        logic [ROB_W-1:0]   rob_idx;
        logic [EPOCH_W-1:0] epoch;
    } rs_uop_t;
endpackage

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [FU_NUM-1:0]                  rs_valid,
    output logic [FU_NUM-1:0]                  rs_ready,
    input  rs_uop_t [FU_NUM-1:0]               rs_uop,
    output logic [2*FU_NUM-1:0][PHYS_W-1:0]    prf_raddr,
    input  logic [2*FU_NUM-1:0][DATA_W-1:0]    prf_rdata,
    input  logic                               wb_valid,
    input  logic [PHYS_W-1:0]                  wb_pd,
    input  logic [DATA_W-1:0]                  wb_data,
    output logic [FU_NUM-1:0]                  ex_valid,
    input  logic [FU_NUM-1:0]                  ex_ready,
    output rs_uop_t [FU_NUM-1:0]               ex_uop,
    output logic [FU_NUM-1:0][DATA_W-1:0]      ex_src1,
    output logic [FU_NUM-1:0][DATA_W-1:0]      ex_src2,
    input  logic                               flush_valid,
    input  logic                               recover_valid,
    input  logic [ROB_W-1:0]                   recover_rob_idx,
    input  logic [EPOCH_W-1:0]                 recover_epoch,
    output logic [31:0]                        issued_cnt
);

    logic [FU_NUM-1:0]             capture;
    logic [FU_NUM-1:0]             kill_match;
    logic [FU_NUM-1:0][DATA_W-1:0] sel_src1;
    logic [FU_NUM-1:0][DATA_W-1:0] sel_src2;
    logic [31:0]                   issue_inc;

    always_comb begin
        rs_ready   = '0;
        capture    = '0;
        kill_match = '0;
        sel_src1   = '0;
        sel_src2   = '0;
        prf_raddr  = '0;
        issue_inc  = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            prf_raddr[2*f]   = rs_uop[f].prs1;
            prf_raddr[2*f+1] = rs_uop[f].prs2;

            // The CDB result is not yet in the PRF read data this cycle, so it wins.
            if (!rs_uop[f].uses_rs1)
                sel_src1[f] = '0;
            else if (wb_valid && wb_pd == rs_uop[f].prs1)
                sel_src1[f] = wb_data;
            else
                sel_src1[f] = prf_rdata[2*f];

            if (!rs_uop[f].uses_rs2)
                sel_src2[f] = '0;
            else if (wb_valid && wb_pd == rs_uop[f].prs2)
                sel_src2[f] = wb_data;
            else
                sel_src2[f] = prf_rdata[2*f+1];

            rs_ready[f]   = !flush_valid && !recover_valid && (!ex_valid[f] || ex_ready[f]);
            capture[f]    = rs_valid[f] && rs_ready[f];
            kill_match[f] = ex_valid[f] && ex_uop[f].rob_idx == recover_rob_idx
                            && ex_uop[f].epoch == recover_epoch;
            issue_inc     = issue_inc + {31'd0, capture[f]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= '0;
            ex_uop     <= '0;
            ex_src1    <= '0;
            ex_src2    <= '0;
            issued_cnt <= '0;
        end else begin
            issued_cnt <= issued_cnt + issue_inc;
            for (int f = 0; f < FU_NUM; f++) begin
                if (flush_valid) begin
                    ex_valid[f] <= 1'b0;
                end else if (recover_valid) begin
                    // Non-matching lanes hold even if the FU is ready: no drain on recover cycles.
                    if (kill_match[f])
                        ex_valid[f] <= 1'b0;
                end else if (capture[f]) begin
                    ex_valid[f] <= 1'b1;
                    ex_uop[f]   <= rs_uop[f];
                    ex_src1[f]  <= sel_src1[f];
                    ex_src2[f]  <= sel_src2[f];
                end else if (ex_valid[f] && ex_ready[f]) begin
                    ex_valid[f] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int DATA_W = 32;

    logic                            clk;
    logic                            rst_n;
    logic [FU_NUM-1:0]               rs_valid;
    logic [FU_NUM-1:0]               rs_ready;
    rs_uop_t [FU_NUM-1:0]            rs_uop;
    logic [2*FU_NUM-1:0][PHYS_W-1:0] prf_raddr;
    logic [2*FU_NUM-1:0][DATA_W-1:0] prf_rdata;
    logic                            wb_valid;
    logic [PHYS_W-1:0]               wb_pd;
    logic [DATA_W-1:0]               wb_data;
    logic [FU_NUM-1:0]               ex_valid;
    logic [FU_NUM-1:0]               ex_ready;
    rs_uop_t [FU_NUM-1:0]            ex_uop;
    logic [FU_NUM-1:0][DATA_W-1:0]   ex_src1;
    logic [FU_NUM-1:0][DATA_W-1:0]   ex_src2;
    logic                            flush_valid;
    logic                            recover_valid;
    logic [ROB_W-1:0]                recover_rob_idx;
    logic [EPOCH_W-1:0]              recover_epoch;
    logic [31:0]                     issued_cnt;

    logic [DATA_W-1:0] prf_mem [128];
    int checks;
    int errors;

    operand_fetch #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_uop(rs_uop),
        .prf_raddr(prf_raddr), .prf_rdata(prf_rdata),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_uop(ex_uop),
        .ex_src1(ex_src1), .ex_src2(ex_src2),
        .flush_valid(flush_valid), .recover_valid(recover_valid),
        .recover_rob_idx(recover_rob_idx), .recover_epoch(recover_epoch),
        .issued_cnt(issued_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @* begin
        for (int p = 0; p < 2*FU_NUM; p++)
            prf_rdata[p] = prf_mem[prf_raddr[p]];
    end

    function automatic rs_uop_t mk_uop(input logic [PHYS_W-1:0] p1, input logic [PHYS_W-1:0] p2,
                                       input logic u1, input logic u2,
                                       input logic [ROB_W-1:0] rob, input logic [EPOCH_W-1:0] ep);
        rs_uop_t u;
        u = '0;
        u.opcode = 8'h40 + {2'b0, rob};
        u.pd = 7'd100;
        u.prs1 = p1;
        u.prs2 = p2;
        u.uses_rs1 = u1;
        u.uses_rs2 = u2;
        u.rob_idx = rob;
        u.epoch = ep;
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rs_uop[1] = mk_uop(7'd3, 7'd4, 1'b1, 1'b1, 6'd0, 2'd0);
        #2;
        checks++;
        if (ex_valid !== 3'b000) begin errors++; $display("FAIL reset_ex_valid got %b want 000", ex_valid); end
        checks++;
        if (issued_cnt !== 32'd0) begin errors++; $display("FAIL reset_issued_cnt got %0d want 0", issued_cnt); end
        checks++;
        if (ex_src1 !== '0 || ex_src2 !== '0 || ex_uop !== '0) begin
            errors++; $display("FAIL reset_ex_data got src1=%h src2=%h want 0", ex_src1, ex_src2);
        end
        checks++;
        if (rs_ready !== 3'b111) begin errors++; $display("FAIL reset_rs_ready got %b want 111", rs_ready); end
        checks++;
        if (prf_raddr[2] !== 7'd3 || prf_raddr[3] !== 7'd4) begin
            errors++; $display("FAIL raddr_lane1 got %0d/%0d want 3/4", prf_raddr[2], prf_raddr[3]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        rs_uop[0] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'd1, 2'd0);
        rs_valid = 3'b001;
        step();
        rs_valid = 3'b000;
        checks++;
        if (ex_valid !== 3'b001) begin errors++; $display("FAIL basic_valid got %b want 001", ex_valid); end
        checks++;
        if (ex_src1[0] !== 32'h11 || ex_src2[0] !== 32'h22) begin
            errors++; $display("FAIL basic_src got %h/%h want 11/22", ex_src1[0], ex_src2[0]);
        end
        checks++;
        if (issued_cnt !== 32'd1) begin errors++; $display("FAIL basic_cnt got %0d want 1", issued_cnt); end
        checks++;
        if (ex_uop[0].rob_idx !== 6'd1) begin errors++; $display("FAIL basic_uop got %0d want 1", ex_uop[0].rob_idx); end
        step();
        checks++;
        if (ex_valid !== 3'b000) begin errors++; $display("FAIL basic_drain got %b want 000", ex_valid); end
    endtask

    task automatic test_bypass();
        rs_uop[0] = mk_uop(7'd9, 7'd7, 1'b1, 1'b0, 6'd2, 2'd0);
        rs_uop[1] = mk_uop(7'd5, 7'd9, 1'b1, 1'b1, 6'd3, 2'd0);
        rs_valid = 3'b011;
        wb_valid = 1'b1;
        wb_pd = 7'd9;
        wb_data = 32'hABCD;
        step();
        rs_valid = 3'b000;
        wb_valid = 1'b0;
        checks++;
        if (ex_src1[0] !== 32'hABCD || ex_src2[0] !== 32'h0) begin
            errors++; $display("FAIL bypass_lane0 got %h/%h want abcd/0", ex_src1[0], ex_src2[0]);
        end
        checks++;
        if (ex_src1[1] !== 32'h11 || ex_src2[1] !== 32'hABCD) begin
            errors++; $display("FAIL bypass_lane1 got %h/%h want 11/abcd", ex_src1[1], ex_src2[1]);
        end
        checks++;
        if (issued_cnt !== 32'd3) begin errors++; $display("FAIL bypass_cnt got %0d want 3", issued_cnt); end
        step();
    endtask

    task automatic test_backpressure();
        ex_ready = 3'b101;
        rs_uop[1] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'd10, 2'd0);
        rs_valid = 3'b010;
        step();
        rs_uop[1] = mk_uop(7'd7, 7'd5, 1'b1, 1'b1, 6'd11, 2'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rs_ready[1] !== 1'b0) begin errors++; $display("FAIL stall_rs_ready c%0d got %b want 0", c, rs_ready[1]); end
            step();
            checks++;
            if (ex_valid[1] !== 1'b1 || ex_uop[1].rob_idx !== 6'd10 || ex_src1[1] !== 32'h11 || ex_src2[1] !== 32'h22) begin
                errors++; $display("FAIL stall_hold c%0d got v=%b rob=%0d src=%h/%h want 1/10/11/22",
                                   c, ex_valid[1], ex_uop[1].rob_idx, ex_src1[1], ex_src2[1]);
            end
        end
        ex_ready = 3'b111;
        #1;
        checks++;
        if (rs_ready[1] !== 1'b1) begin errors++; $display("FAIL release_rs_ready got %b want 1", rs_ready[1]); end
        step();
        rs_valid = 3'b000;
        checks++;
        if (ex_valid[1] !== 1'b1 || ex_uop[1].rob_idx !== 6'd11 || ex_src1[1] !== 32'h22 || ex_src2[1] !== 32'h11) begin
            errors++; $display("FAIL replace got v=%b rob=%0d src=%h/%h want 1/11/22/11",
                               ex_valid[1], ex_uop[1].rob_idx, ex_src1[1], ex_src2[1]);
        end
        checks++;
        if (issued_cnt !== 32'd5) begin errors++; $display("FAIL bp_cnt got %0d want 5", issued_cnt); end
        step();
    endtask

    task automatic test_recover();
        ex_ready = 3'b000;
        rs_uop[0] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'd4, 2'd1);
        rs_uop[2] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'd6, 2'd1);
        rs_valid = 3'b101;
        step();
        rs_uop[0] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'd20, 2'd1);
        rs_uop[1] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'd21, 2'd1);
        rs_uop[2] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'd22, 2'd1);
        rs_valid = 3'b111;
        ex_ready = 3'b111;
        recover_valid = 1'b1;
        recover_rob_idx = 6'd6;
        recover_epoch = 2'd1;
        #1;
        checks++;
        if (rs_ready !== 3'b000) begin errors++; $display("FAIL recover_rs_ready got %b want 000", rs_ready); end
        step();
        recover_valid = 1'b0;
        rs_valid = 3'b000;
        ex_ready = 3'b000;
        checks++;
        if (ex_valid !== 3'b001 || ex_uop[0].rob_idx !== 6'd4) begin
            errors++; $display("FAIL recover_kill got v=%b rob0=%0d want 001/4", ex_valid, ex_uop[0].rob_idx);
        end
        checks++;
        if (issued_cnt !== 32'd7) begin errors++; $display("FAIL recover_cnt got %0d want 7", issued_cnt); end
    endtask

    task automatic test_flush();
        rs_valid = 3'b111;
        flush_valid = 1'b1;
        #1;
        checks++;
        if (rs_ready !== 3'b000) begin errors++; $display("FAIL flush_rs_ready got %b want 000", rs_ready); end
        step();
        flush_valid = 1'b0;
        rs_valid = 3'b000;
        checks++;
        if (ex_valid !== 3'b000) begin errors++; $display("FAIL flush_valid got %b want 000", ex_valid); end
        checks++;
        if (issued_cnt !== 32'd7) begin errors++; $display("FAIL flush_cnt got %0d want 7", issued_cnt); end
    endtask

    task automatic test_back_to_back();
        ex_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            rs_uop[2] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'(30 + i), 2'd2);
            rs_valid = 3'b100;
            step();
            checks++;
            if (ex_valid !== 3'b100 || ex_uop[2].rob_idx !== 6'(30 + i)) begin
                errors++; $display("FAIL b2b_%0d got v=%b rob=%0d want 100/%0d", i, ex_valid, ex_uop[2].rob_idx, 30 + i);
            end
        end
        rs_valid = 3'b000;
        checks++;
        if (issued_cnt !== 32'd10) begin errors++; $display("FAIL b2b_cnt got %0d want 10", issued_cnt); end
        step();
    endtask

    task automatic test_async_reset();
        ex_ready = 3'b000;
        rs_uop[0] = mk_uop(7'd5, 7'd7, 1'b1, 1'b1, 6'd40, 2'd0);
        rs_uop[1] = mk_uop(7'd7, 7'd5, 1'b1, 1'b1, 6'd41, 2'd0);
        rs_valid = 3'b011;
        step();
        rs_valid = 3'b000;
        step();
        checks++;
        if (ex_valid !== 3'b011) begin errors++; $display("FAIL pre_reset_valid got %b want 011", ex_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 3'b000 || issued_cnt !== 32'd0) begin
            errors++; $display("FAIL async_reset got v=%b cnt=%0d want 000/0", ex_valid, issued_cnt);
        end
        checks++;
        if (ex_uop !== '0 || ex_src1 !== '0 || ex_src2 !== '0) begin
            errors++; $display("FAIL async_reset_data got src1=%h src2=%h want 0", ex_src1, ex_src2);
        end
        checks++;
        if (rs_ready !== 3'b111) begin errors++; $display("FAIL async_reset_rs_ready got %b want 111", rs_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 128; i++) prf_mem[i] = 32'h1000 + i;
        prf_mem[5] = 32'h11;
        prf_mem[7] = 32'h22;
        prf_mem[9] = 32'hDEAD;
        rst_n = 1'b0;
        rs_valid = '0;
        rs_uop = '0;
        wb_valid = 1'b0;
        wb_pd = '0;
        wb_data = '0;
        ex_ready = 3'b111;
        flush_valid = 1'b0;
        recover_valid = 1'b0;
        recover_rob_idx = '0;
        recover_epoch = '0;

        test_reset();
        test_basic();
        test_bypass();
        test_backpressure();
        test_recover();
        test_flush();
        test_back_to_back();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
